operand_sequencer: RTL and testbench
====================================

# operand_sequencer

Upstream front end for the 8-bit adder datapath. Converts a raw, bouncy push-button into one clean load event per press and uses those events to load switch values into operand registers A and B in turn. The registered operands drive the adder and the seven-segment scan controller directly. Replaces the practice of using a slide switch as the load clock: the whole block runs on the 100 MHz board clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive clock edges (10 ms at 100 MHz) a changed button level must persist before it is accepted; legal range ≥2.
- WIDTH, default 8: operand width.

Ports:
- CLK100MHZ  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low; sampled on the CLK100MHZ rising edge.
- BTN  in  1  raw load button, asynchronous and bouncy, active-high.
- SW  in  WIDTH  operand value from the slide switches; quasi-static.
- INPUT_A  out  WIDTH  registered operand A.
- INPUT_B  out  WIDTH  registered operand B.
- operands_valid  out  1  high while both operands belong to the current pair.
- load_phase  out  2  state encoding for status LEDs: 00 WAIT_A, 01 WAIT_B, 10 SHOW.
- load_strobe  out  1  one-cycle pulse in the cycle after any operand capture.

## Operation
- Synchronizer: BTN passes through two flip-flops (s1, s2). No logic reads BTN or s1 directly.
- Debouncer: holds a debounced level `deb` and a counter.
  - On an edge where s2 == deb, the counter clears.
  - On an edge where s2 != deb and count < DEBOUNCE_CYCLES-1, the counter increments.
  - On an edge where s2 != deb and count == DEBOUNCE_CYCLES-1, `deb` takes the value of s2 and the counter clears.
- Press event: the edge on which `deb` goes 0→1. A release (1→0) produces no event.
- FSM, one transition per press event:
  - WAIT_A + press: INPUT_A <= SW, operands_valid <= 0, next state WAIT_B.
  - WAIT_B + press: INPUT_B <= SW, operands_valid <= 1, next state SHOW.
  - SHOW + press: INPUT_A <= SW, operands_valid <= 0, next state WAIT_B. INPUT_B holds its old value until it is reloaded.
  - With no press event, the state and all outputs hold.
- SW is sampled without synchronization, directly on the capture edge. Operators must hold the switches stable while pressing.
- load_strobe is registered: it is high for exactly the one cycle after each capture edge.

## Timing
- Reset (reset == 0 at an edge) sets all of the following on that edge: INPUT_A = 0, INPUT_B = 0, operands_valid = 0, load_strobe = 0, load_phase = 00, s1 = s2 = deb = 0, counter = 0.
- Reset has priority over every other event, including a press event on the same edge.
- Reset mid-sequence (for example in WAIT_B with A already loaded) discards A and returns the block to WAIT_A.
- Latency: BTN is first sampled high at edge 0 and held stable. s2 = 1 after edge 1. The capture occurs on edge DEBOUNCE_CYCLES+1, and load_strobe is high during the following cycle.
- Glitch rejection: a BTN high or low pulse that yields fewer than DEBOUNCE_CYCLES consecutive mismatch edges at s2 leaves `deb` unchanged and produces no event.
- Holding the button pressed produces exactly one event. A second event requires a debounced release followed by a debounced press.
- Capture behaviour: INPUT_A, INPUT_B and operands_valid change only on capture edges or reset. Downstream logic may use them combinationally with no handshake.
- The counter needs ceil(log2(DEBOUNCE_CYCLES)) bits and must never wrap. It saturates by design at the clear condition.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and WIDTH=8.
- Reset: assert reset=0 for 2 edges with BTN=1 and SW=8'hFF → INPUT_A=00, INPUT_B=00, operands_valid=0, load_phase=00, no load_strobe.
- Clean load pair: SW=8'h3C, BTN held high from edge 0 → INPUT_A=3C at edge 5 and load_strobe high for one cycle. Release the button for ≥8 cycles, set SW=8'hA5, press again → INPUT_B=A5, operands_valid=1, load_phase=10.
- Bounce rejection: BTN toggles 1,0,1,0 every edge for 10 edges, then returns to 0 → no capture, load_phase stays 00, counter returns to 0.
- Hold: BTN held high for 50 cycles → exactly one load_strobe pulse and exactly one state advance.
- Wrap from SHOW: with A=3C and B=A5 loaded, SW=8'h01, press → INPUT_A=01, INPUT_B stays A5, operands_valid=0, load_phase=01.
- Reset mid-operation: in WAIT_B, drive reset=0 on the same edge on which the press would capture → INPUT_A=00, state WAIT_A, no load_strobe on the next cycle.

Source files
------------

// File: rtl/operand_sequencer.sv
// Push-button front end for the adder: synchronizes and debounces BTN, then
// loads SW into operand A and B on alternating presses.
module operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int WIDTH           = 8
) (
   input  logic             CLK100MHZ,
   input  logic             reset,
   input  logic             BTN,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] INPUT_A,
   output logic [WIDTH-1:0] INPUT_B,
   output logic             operands_valid,
   output logic [1:0]       load_phase,
   output logic             load_strobe
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_A = 2'b00,
      WAIT_B = 2'b01,
      SHOW   = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s2_q;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             valid_q, valid_d;
   logic             strobe_q, strobe_d;
   logic             press;

   // A press is the edge on which the debounced level is about to rise.
   assign press = s2_q && !deb_q && (cnt_q == CNT_MAX);

   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         deb_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!reset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         deb_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= BTN;
         s2_q  <= s1_q;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!reset) state_q <= WAIT_A;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (press) begin
         case (state_q)
            WAIT_A:  state_d = WAIT_B;
            WAIT_B:  state_d = SHOW;
            SHOW:    state_d = WAIT_B;
            default: state_d = WAIT_A;
         endcase
      end
   end

   // SW is sampled raw on the capture edge; operators hold it steady while pressing.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      valid_d  = valid_q;
      strobe_d = press;
      if (press) begin
         case (state_q)
            WAIT_B: begin
               b_d     = SW;
               valid_d = 1'b1;
            end
            default: begin
               a_d     = SW;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
      end
   end

   assign INPUT_A        = a_q;
   assign INPUT_B        = b_q;
   assign operands_valid = valid_q;
   assign load_phase     = state_q;
   assign load_strobe    = strobe_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_operand_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic [7:0] sw;
   logic [7:0] in_a, in_b;
   logic       valid;
   logic [1:0] phase;
   logic       strobe;

   int n_checks = 0;
   int n_fail   = 0;
   int strobe_cnt = 0;
   int base;

   always #5 clk = ~clk;

   operand_sequencer #(.DEBOUNCE_CYCLES(4), .WIDTH(8)) dut (
      .CLK100MHZ      (clk),
      .reset          (reset),
      .BTN            (btn),
      .SW             (sw),
      .INPUT_A        (in_a),
      .INPUT_B        (in_b),
      .operands_valid (valid),
      .load_phase     (phase),
      .load_strobe    (strobe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past n rising edges, sampling 1 time unit after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (strobe) strobe_cnt++;
      end
   endtask

   initial begin
      reset = 1'b0;
      btn   = 1'b1;
      sw    = 8'hFF;
      step(2);
      check("rst_a",      32'(in_a),   32'h00);
      check("rst_b",      32'(in_b),   32'h00);
      check("rst_valid",  32'(valid),  32'h0);
      check("rst_phase",  32'(phase),  32'h0);
      check("rst_strobe", 32'(strobe), 32'h0);

      // Clean load of A: BTN first sampled at edge 0, capture at edge 5.
      btn = 1'b0;
      step(1);
      reset = 1'b1;
      sw    = 8'h3C;
      btn   = 1'b1;
      step(5);
      check("a_early",    32'(in_a),   32'h00);
      check("strobe_early", 32'(strobe), 32'h0);
      step(1);
      check("a_load",     32'(in_a),   32'h3C);
      check("a_strobe",   32'(strobe), 32'h1);
      check("a_phase",    32'(phase),  32'h1);
      check("a_valid",    32'(valid),  32'h0);
      step(1);
      check("a_strobe_off", 32'(strobe), 32'h0);

      btn = 1'b0;
      step(10);
      sw  = 8'hA5;
      btn = 1'b1;
      step(6);
      check("b_load",     32'(in_b),   32'hA5);
      check("b_valid",    32'(valid),  32'h1);
      check("b_phase",    32'(phase),  32'h2);
      check("b_strobe",   32'(strobe), 32'h1);
      check("b_keep_a",   32'(in_a),   32'h3C);

      // Wrap from SHOW back into WAIT_B with a fresh A.
      btn = 1'b0;
      step(10);
      sw  = 8'h01;
      btn = 1'b1;
      step(6);
      check("wrap_a",     32'(in_a),   32'h01);
      check("wrap_b",     32'(in_b),   32'hA5);
      check("wrap_valid", 32'(valid),  32'h0);
      check("wrap_phase", 32'(phase),  32'h1);

      // Reset on the very edge that would capture B.
      btn = 1'b0;
      step(10);
      sw  = 8'h77;
      btn = 1'b1;
      step(5);
      reset = 1'b0;
      base  = strobe_cnt;
      step(1);
      check("mid_rst_a",     32'(in_a),  32'h00);
      check("mid_rst_b",     32'(in_b),  32'h00);
      check("mid_rst_phase", 32'(phase), 32'h0);
      reset = 1'b1;
      btn   = 1'b0;
      step(1);
      check("mid_rst_strobe", 32'(strobe_cnt - base), 32'd0);
      check("mid_rst_phase2", 32'(phase), 32'h0);

      // Bounce: BTN alternates every edge for 10 edges.
      step(10);
      base = strobe_cnt;
      for (int i = 0; i < 10; i++) begin
         btn = (i % 2 == 0);
         step(1);
      end
      btn = 1'b0;
      step(6);
      check("bounce_phase",   32'(phase),  32'h0);
      check("bounce_strobes", 32'(strobe_cnt - base), 32'd0);
      check("bounce_cnt",     32'(dut.cnt_q), 32'd0);
      check("bounce_a",       32'(in_a),   32'h00);

      // Hold: 50 cycles pressed gives one event only.
      sw   = 8'h5A;
      base = strobe_cnt;
      btn  = 1'b1;
      step(50);
      check("hold_strobes", 32'(strobe_cnt - base), 32'd1);
      check("hold_phase",   32'(phase), 32'h1);
      check("hold_a",       32'(in_a),  32'h5A);
      btn = 1'b0;
      step(10);
      check("release_phase", 32'(phase), 32'h1);
      check("release_strobes", 32'(strobe_cnt - base), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
